// File: rtl/current_trip_monitor.sv
// Overcurrent trip monitor: counts consecutive over-threshold ADC sums per row,
// latches per-row faults, pulses a trip strobe and tracks peak current.
module current_trip_monitor #(
  parameter int SUM_WIDTH  = 16,
  parameter int ROWS       = 32,
  parameter int ROW_AWIDTH = 5,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  enable,
  input  logic                  sum_valid,
  input  logic [SUM_WIDTH-1:0]  adc_sum,
  input  logic [ROW_AWIDTH-1:0] cal_row,
  input  logic [SUM_WIDTH-1:0]  threshold,
  input  logic [CNT_WIDTH-1:0]  trip_count,
  input  logic                  fault_clear,
  output logic [ROWS-1:0]       fault_row,
  output logic                  fault_any,
  output logic                  trip,
  output logic [ROW_AWIDTH-1:0] trip_row,
  output logic [SUM_WIDTH-1:0]  peak_sum,
  output logic [ROW_AWIDTH-1:0] peak_row,
  output logic [15:0]           sample_count
);

  typedef enum logic [1:0] {IDLE, MONITOR, TRIPPED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  consec_q, consec_d;
  logic [ROW_AWIDTH-1:0] last_row_q, last_row_d;
  logic [ROWS-1:0]       fault_q, fault_d;
  logic                  fault_any_q, fault_any_d;
  logic                  trip_q, trip_d;
  logic [ROW_AWIDTH-1:0] trip_row_q, trip_row_d;
  logic [SUM_WIDTH-1:0]  peak_q, peak_d;
  logic [ROW_AWIDTH-1:0] peak_row_q, peak_row_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  in_range, accept, over;
  logic [ROWS-1:0]       row_oh;
  logic [CNT_WIDTH-1:0]  tc_eff;

  assign in_range = 32'(cal_row) < ROWS;
  assign accept   = enable && (state_q != IDLE) && sum_valid && in_range;
  assign over     = adc_sum > threshold;
  assign row_oh   = {{(ROWS-1){1'b0}}, 1'b1} << cal_row;
  assign tc_eff   = (trip_count == '0) ? CNT_ONE : trip_count;

  // Clear is applied before the same-cycle sample so a new trip survives it.
  always_comb begin
    fault_d     = fault_clear ? '0 : fault_q;
    consec_d    = (fault_clear || !enable) ? '0 : consec_q;
    peak_d      = fault_clear ? '0 : peak_q;
    peak_row_d  = fault_clear ? '0 : peak_row_q;
    cnt_d       = fault_clear ? '0 : cnt_q;
    last_row_d  = last_row_q;
    trip_d      = 1'b0;
    trip_row_d  = trip_row_q;
    fault_any_d = |fault_q;
    if (accept) begin
      if (cal_row != last_row_q) begin
        consec_d   = {{(CNT_WIDTH-1){1'b0}}, over};
        last_row_d = cal_row;
      end else if (over) begin
        consec_d = (consec_d == CNT_MAX) ? CNT_MAX : consec_d + CNT_ONE;
      end else begin
        consec_d = '0;
      end
      if (consec_d >= tc_eff && (fault_d & row_oh) == '0) begin
        fault_d    = fault_d | row_oh;
        trip_d     = 1'b1;
        trip_row_d = cal_row;
      end
      if (adc_sum > peak_d) begin
        peak_d     = adc_sum;
        peak_row_d = cal_row;
      end
      if (cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    end
    if (soft_reset) begin
      fault_d     = '0;
      consec_d    = '0;
      peak_d      = '0;
      peak_row_d  = '0;
      cnt_d       = '0;
      last_row_d  = '0;
      trip_d      = 1'b0;
      trip_row_d  = '0;
      fault_any_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      consec_q    <= '0;
      last_row_q  <= '0;
      fault_q     <= '0;
      fault_any_q <= 1'b0;
      trip_q      <= 1'b0;
      trip_row_q  <= '0;
      peak_q      <= '0;
      peak_row_q  <= '0;
      cnt_q       <= '0;
    end else begin
      consec_q    <= consec_d;
      last_row_q  <= last_row_d;
      fault_q     <= fault_d;
      fault_any_q <= fault_any_d;
      trip_q      <= trip_d;
      trip_row_q  <= trip_row_d;
      peak_q      <= peak_d;
      peak_row_q  <= peak_row_d;
      cnt_q       <= cnt_d;
      if (soft_reset || !enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= MONITOR;
          MONITOR: if (trip_d) state_q <= TRIPPED;
          TRIPPED: if (fault_clear && !trip_d) state_q <= MONITOR;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fault_row    = fault_q;
  assign fault_any    = fault_any_q;
  assign trip         = trip_q;
  assign trip_row     = trip_row_q;
  assign peak_sum     = peak_q;
  assign peak_row     = peak_row_q;
  assign sample_count = cnt_q;

endmodule
